// File: rtl/arb_burst_mux.sv
// arb_burst_mux
//   Sits downstream of a round-robin arbiter. When a valid one-hot grant
//   arrives, it latches the owning requester. It then moves that requester's
//   multi-beat burst onto one shared valid/ready output channel. When the
//   burst ends, it releases the channel and pulses the owner's done bit.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   grant      one-hot grant from the arbiter (all-zero = no grant)
//   src_len    per-requester burst length, LENW bits each (0 acts as 1)
//   src_data   per-requester beat data, DW bits each
//   src_valid  per-requester beat valid
//   src_ready  per-requester beat accept (only the owner's bit can rise)
//   out_data   current beat data from the owner
//   out_valid  output beat valid
//   out_ready  downstream accept
//   out_last   high while the final beat of the burst is presented
//   owner      registered one-hot owner, zero when idle
//   busy       high in BUSY and RELEASE
//   done       one-cycle pulse on the owner's bit when its burst completes
//   grant_err  one-cycle pulse after a malformed grant is seen while idle
module arb_burst_mux #(
   parameter int N    = 4,
   parameter int DW   = 8,
   parameter int LENW = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N-1:0]    grant,
   input  logic [N*LENW-1:0] src_len,
   input  logic [N*DW-1:0] src_data,
   input  logic [N-1:0]    src_valid,
   output logic [N-1:0]    src_ready,
   output logic [DW-1:0]   out_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_last,
   output logic [N-1:0]    owner,
   output logic            busy,
   output logic [N-1:0]    done,
   output logic            grant_err
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

   state_t            state, state_nxt;
   logic [LENW-1:0]   beat_cnt;
   logic [IW-1:0]     grant_idx, owner_idx;
   logic [LENW-1:0]   len_sel, len_init;
   logic              grant_ok, xfer, last_beat;

   // Encode the one-hot vectors into indices for the datapath muxes.
   always_comb begin
      grant_idx = '0;
      owner_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) grant_idx = IW'(i);
         if (owner[i]) owner_idx = IW'(i);
      end
   end

   assign grant_ok  = $onehot(grant);
   assign len_sel   = src_len[grant_idx*LENW +: LENW];
   // A zero-length request still moves one beat.
   assign len_init  = (len_sel == '0) ? LENW'(1) : len_sel;
   assign xfer      = (state == BUSY) && src_valid[owner_idx] && out_ready;
   assign last_beat = (beat_cnt == LENW'(1));

   // State register plus the registered control (owner, count, pulses).
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         owner     <= '0;
         beat_cnt  <= '0;
         done      <= '0;
         grant_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         done      <= '0;
         grant_err <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_ok) begin
                  owner    <= grant;
                  beat_cnt <= len_init;
               end else if (grant != '0) begin
                  grant_err <= 1'b1;
               end
            end
            BUSY: begin
               if (xfer) begin
                  if (last_beat) begin
                     done     <= owner;
                     beat_cnt <= '0;
                  end else begin
                     beat_cnt <= beat_cnt - LENW'(1);
                  end
               end
            end
            RELEASE: owner <= '0;
            default: owner <= '0;
         endcase
      end
   end

   // Next-state logic; grant is only looked at from IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_ok) state_nxt = BUSY;
         BUSY:    if (xfer && last_beat) state_nxt = RELEASE;
         RELEASE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output datapath: the owner's channel is routed straight through in BUSY.
   always_comb begin
      out_valid = 1'b0;
      out_data  = '0;
      out_last  = 1'b0;
      src_ready = '0;
      busy      = (state != IDLE);
      if (state == BUSY) begin
         out_valid = src_valid[owner_idx];
         out_data  = src_data[owner_idx*DW +: DW];
         out_last  = last_beat;
         src_ready = owner & {N{out_ready}};
      end
   end

`ifndef SYNTHESIS
   a_owner_onehot0 : assert property (@(posedge clk) disable iff (reset) $onehot0(owner));
   a_ready_onehot0 : assert property (@(posedge clk) disable iff (reset) $onehot0(src_ready));
   a_ready_owner   : assert property (@(posedge clk) disable iff (reset) (src_ready & ~owner) == '0);
   a_valid_busy    : assert property (@(posedge clk) disable iff (reset) out_valid |-> busy);
   a_done_busy     : assert property (@(posedge clk) disable iff (reset) (|done) |-> ($past(state) == BUSY));
`endif

endmodule

// File: tb/tb_arb_burst_mux.sv
module tb_arb_burst_mux;

   localparam int N = 4, DW = 8, LENW = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [N-1:0]      grant;
   logic [N*LENW-1:0] src_len;
   logic [N*DW-1:0]   src_data;
   logic [N-1:0]      src_valid;
   logic [N-1:0]      src_ready;
   logic [DW-1:0]     out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic [N-1:0]      owner;
   logic              busy;
   logic [N-1:0]      done;
   logic              grant_err;

   int checks = 0;
   int errors = 0;
   logic [DW:0] exp_q[$];   // {last, data}

   always #5 clk = ~clk;

   arb_burst_mux #(.N(N), .DW(DW), .LENW(LENW)) dut (
      .clk(clk), .reset(reset), .grant(grant), .src_len(src_len),
      .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .owner(owner), .busy(busy), .done(done),
      .grant_err(grant_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one beat on requester idx and expect it on the output.
   task automatic send_beat(input int idx, input logic [DW-1:0] d, input logic last);
      src_data[idx*DW +: DW] = d;
      exp_q.push_back({last, d});
      step();
   endtask

   task automatic start(input int idx, input logic [LENW-1:0] len);
      grant = N'(1) << idx;
      src_len[idx*LENW +: LENW] = len;
      step();
      grant = '0;
      check("latch_owner", owner, N'(1) << idx);
      check("latch_busy", busy, 1);
   endtask

   task automatic release_check(input int idx);
      check("rel_done", done, N'(1) << idx);
      check("rel_busy", busy, 1);
      check("rel_valid", out_valid, 0);
      check("rel_ready", src_ready, 0);
      check("rel_drained", exp_q.size(), 0);
      step();
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
      check("idle_owner", owner, 0);
   endtask

   // Scoreboard: a transfer is visible at the negedge before the edge that takes it.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL beat_unexpected: observed data %0h expected no beat", out_data);
         end
         if (exp_q.size() != 0) begin
            logic [DW:0] e;
            e = exp_q.pop_front();
            check("beat_data", out_data, e[DW-1:0]);
            check("beat_last", out_last, e[DW]);
         end
      end
   end

   initial begin
      reset = 1'b1; grant = '0; src_len = '0; src_data = '0;
      src_valid = '1; out_ready = 1'b1;
      step(); step();
      check("rst_owner", owner, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_gerr", grant_err, 0);
      check("rst_valid", out_valid, 0);
      reset = 1'b0;
      step();

      // 1: three-beat burst, no stalls
      start(1, 3);
      send_beat(1, 8'h1A, 0);
      send_beat(1, 8'h1B, 0);
      check("t1_done_early", done, 0);
      send_beat(1, 8'h1C, 1);
      release_check(1);

      // 2: four beats with stalls 1,0,0,1,1,0,1
      start(0, 4);
      send_beat(0, 8'h21, 0);
      out_ready = 0; step(); step();
      check("t2_stall_busy", busy, 1);
      check("t2_stall_ready", src_ready, 0);
      out_ready = 1;
      send_beat(0, 8'h22, 0);
      send_beat(0, 8'h23, 0);
      out_ready = 0; step();
      check("t2_stall_last", out_last, 1);
      check("t2_stall_done", done, 0);
      out_ready = 1;
      send_beat(0, 8'h24, 1);
      release_check(0);

      // 3: malformed grant, then a normal one
      grant = 4'b0110; step();
      check("t3_gerr", grant_err, 1);
      check("t3_owner", owner, 0);
      check("t3_ready", src_ready, 0);
      start(2, 2);
      check("t3_gerr_clr", grant_err, 0);
      send_beat(2, 8'h31, 0);
      send_beat(2, 8'h32, 1);
      release_check(2);

      // 4: zero length acts as one beat
      start(3, 0);
      send_beat(3, 8'h41, 1);
      release_check(3);

      // 5: grant changes during BUSY are ignored
      start(2, 5);
      send_beat(2, 8'h51, 0);
      send_beat(2, 8'h52, 0);
      grant = 4'b0001;
      send_beat(2, 8'h53, 0);
      check("t5_owner_a", owner, 4'b0100);
      grant = 4'b0011;
      send_beat(2, 8'h54, 0);
      check("t5_owner_b", owner, 4'b0100);
      check("t5_gerr", grant_err, 0);
      grant = '0;
      send_beat(2, 8'h55, 1);
      release_check(2);

      // 6: reset mid-burst aborts it
      start(1, 6);
      send_beat(1, 8'h61, 0);
      send_beat(1, 8'h62, 0);
      reset = 1; out_ready = 0; step();
      check("t6_owner", owner, 0);
      check("t6_busy", busy, 0);
      check("t6_valid", out_valid, 0);
      check("t6_ready", src_ready, 0);
      check("t6_done", done, 0);
      reset = 0; out_ready = 1; step();
      check("t6_done_after", done, 0);
      start(1, 6);
      for (int i = 0; i < 6; i++) send_beat(1, 8'h70 + 8'(i), i == 5);
      release_check(1);

      step();
      check("final_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
